// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit buffer: serializer states and frame constants.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_state_e;

    localparam int unsigned DATA_BITS           = 8;
    localparam int unsigned DEFAULT_CLK_PER_BIT = 868;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; caller must not push when full unless popping.
module sync_fifo #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH_LOG = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout,
    output logic [DEPTH_LOG:0]   count
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG;

    logic [WIDTH-1:0]     mem_q [Depth];
    logic [DEPTH_LOG-1:0] wptr_q, rptr_q;
    logic [DEPTH_LOG:0]   count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (DEPTH_LOG+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (DEPTH_LOG+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + DEPTH_LOG'(1);
            if (pop)  rptr_q <= rptr_q + DEPTH_LOG'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= din;
    end

    assign dout  = mem_q[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffers one-cycle byte strobes in a FIFO and serializes them as back-to-back 8N1 frames.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter int unsigned DEPTH_LOG   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_ready,
    input  logic [7:0]           sdata,
    output logic                 txd,
    output logic                 busy,
    output logic                 overflow,
    output logic [DEPTH_LOG:0]   fifo_count
);

    localparam int unsigned BaudW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [BaudW-1:0]   BaudLast = BaudW'(CLK_PER_BIT - 1);
    localparam logic [DEPTH_LOG:0] Depth    = (DEPTH_LOG+1)'(2 ** DEPTH_LOG);

    uart_state_e            state_q;
    logic [BaudW-1:0]       baud_q;
    logic [2:0]             bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   txd_q;
    logic                   overflow_q;

    logic [DATA_BITS-1:0]   fifo_dout;
    logic [DEPTH_LOG:0]     fifo_cnt;
    logic                   fifo_push, fifo_pop, baud_last;

    assign baud_last = (baud_q == BaudLast);
    assign fifo_pop  = (fifo_cnt != '0) &&
                       ((state_q == StIdle) || ((state_q == StStop) && baud_last));
    // A full FIFO still accepts when the head leaves on the same edge.
    assign fifo_push = tx_ready && ((fifo_cnt < Depth) || fifo_pop);

    sync_fifo #(
        .WIDTH     (DATA_BITS),
        .DEPTH_LOG (DEPTH_LOG)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (sdata),
        .dout  (fifo_dout),
        .count (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (tx_ready && !fifo_push) overflow_q <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (fifo_pop) begin
                        shift_q <= fifo_dout;
                        state_q <= StStart;
                        baud_q  <= '0;
                        txd_q   <= 1'b0;
                    end
                end
                StStart: begin
                    if (baud_last) begin
                        state_q <= StData;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        txd_q   <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                StData: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == 3'(DATA_BITS - 1)) begin
                            state_q <= StStop;
                            txd_q   <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                StStop: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (fifo_pop) begin
                            shift_q <= fifo_dout;
                            state_q <= StStart;
                            txd_q   <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign txd        = txd_q;
    assign overflow   = overflow_q;
    assign fifo_count = fifo_cnt;
    assign busy       = (state_q != StIdle) || (fifo_cnt != '0);

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Downstream consumer of the core's transmit port.
- The core pulses tx_ready for exactly one cycle with the byte on sdata and never stalls, so this block must always accept the byte.
- The byte is queued in a small FIFO, then serialized as 8N1 UART on txd at a fixed bit period.
- A sticky overflow flag reports any byte dropped because the FIFO was full.

Parameters:
CLK_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal values are 2 or more.
DEPTH_LOG, 4, log2 of FIFO depth (default 16 entries).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
tx_ready  input  1  one-cycle push strobe from the core.
sdata  input  8  byte to transmit; valid only when tx_ready=1.
txd  output  1  UART serial line, idles high; registered.
busy  output  1  1 when the FIFO is non-empty or a frame is in progress.
overflow  output  1  sticky; set when a push is dropped.
fifo_count  output  DEPTH_LOG+1  number of bytes currently queued, excluding the frame in flight.

Behaviour:
- Reset: one clock; rst is synchronous and active-high. Sampled at a rising edge of clk, it sets txd=1, busy=0, overflow=0, fifo_count=0, state=IDLE, and clears the FIFO pointers and the bit/baud counters.
- Reset mid-frame: the frame is aborted and txd=1 from the edge at which rst is sampled. Queued bytes are discarded.
- Push: on an edge with tx_ready=1, sdata is written to the FIFO tail if either condition holds:
  - fifo_count < 2^DEPTH_LOG, or
  - a pop occurs on the same edge.
  Otherwise the byte is dropped and overflow<=1. overflow stays set until rst.
- Pop: on an edge where state=IDLE and fifo_count!=0, the head byte is loaded into the shift register, state<=START and txd<=0 on that same edge.
- Pop at end of frame: on the last cycle of STOP, if fifo_count!=0, the next byte is popped directly into START. There is no idle gap between frames.
- fifo_count: +1 on a push, -1 on a pop, unchanged when both occur, and unchanged when a push is dropped.
- Latency: if a push is sampled at edge E0 while IDLE and the FIFO is empty, fifo_count=1 after E0. The pop happens at E1, and txd falls after E1.
- FSM states and transitions:
  - IDLE: txd=1. Goes to START on a pop.
  - START: txd=0 for CLK_PER_BIT cycles, then goes to DATA with bit index 0.
  - DATA: txd=shift[0], each bit held CLK_PER_BIT cycles, LSB first. Bit index counts 0..7. After bit 7 completes, goes to STOP.
  - STOP: txd=1 for CLK_PER_BIT cycles, then goes to START if the FIFO is non-empty, else IDLE.
- Frame length: exactly 10*CLK_PER_BIT cycles.
- Baud counter: counts 0..CLK_PER_BIT-1 and resets to 0 on every state or bit change. It needs clog2(CLK_PER_BIT) bits.
- busy = (state!=IDLE) | (fifo_count!=0), derived combinationally from registers.
- FIFO pointers: DEPTH_LOG-bit read and write pointers with natural wrap-around. fifo_count disambiguates full from empty.
- sdata is sampled only when tx_ready=1. Any other value on sdata is ignored.

Decomposition:
- Shared package (uart_pkg) holds:
  - state encodings: IDLE, START, DATA, STOP as 2-bit localparams;
  - DATA_BITS=8;
  - default CLK_PER_BIT.
- One sub-module: sync_fifo (width 8, depth 2^DEPTH_LOG) with ports push, pop, din, dout, count. Reads are first-word-fall-through, so dout always shows the head byte.
- The serializer FSM lives in uart_tx_buffer itself.

Test Plan:
- Single byte (CLK_PER_BIT=4): push 0x41 at cycle 0 -> txd=0 on cycles 2-5, then bits 1,0,0,0,0,0,1,0 (4 cycles each), then stop=1 on cycles 38-41. busy falls after cycle 41, overflow=0.
- Back-to-back: push 0x55, 0xAA, 0x0F on consecutive cycles -> fifo_count peaks at 2. The three frames are contiguous (30*CLK_PER_BIT cycles, no idle gap) and the bytes arrive in order.
- Overflow (DEPTH_LOG=2): push 6 bytes on consecutive cycles while the first frame is in flight -> the first byte is transmitting, the next 4 are queued (fifo_count=4), and the 6th is dropped. overflow=1 and stays 1 through all frames until rst.
- Push and pop on the same edge when full: fill the FIFO, then push exactly on the STOP-to-START pop edge -> the byte is accepted, fifo_count is unchanged, overflow stays 0.
- Reset mid-frame: assert rst during DATA bit 3 -> txd=1, busy=0, fifo_count=0 and overflow=0 after that edge. A fresh push afterwards transmits normally.
- Idle line: no tx_ready for 1000 cycles after reset -> txd stays 1 and busy stays 0 throughout.
